// File: rtl/r2b_sched_pkg.sv
// Shared definitions for the r2b weight-feed scheduler.
// Holds the FSM state encoding, the geometry derivation helpers used to size
// ports and counters, and the bit positions of the sticky error flags.
package r2b_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Sticky error flag positions
    localparam int ERR_OVF = 0;  // chunk dropped because the FIFO was full
    localparam int ERR_CNT = 1;  // matrix did not produce exactly NUM_OUT chunks

    // Number of converter output chunks making up one matrix
    function automatic int calc_num_out(input int rows, input int cols,
                                        input int chunk, input int cores);
        return (rows * cols) / (chunk * cores);
    endfunction

    // Width of one BRAM row word
    function automatic int calc_data_width(input int width, input int cols);
        return width * cols;
    endfunction

    // Width of one converter output chunk
    function automatic int calc_out_width(input int width, input int chunk, input int cores);
        return width * chunk * cores;
    endfunction

endpackage

// File: rtl/r2b_chunk_fifo.sv
// Synchronous FIFO holding converter output chunks (payload plus last flag).
// Ports: clk/rst_n clock and async active-low reset; push/wdata write side;
// pop/rdata read side (rdata shows the head straight from storage);
// full/empty/count occupancy; overflow pulses for a push dropped while full.
// A push and a pop in the same cycle both take effect, even when full.
module r2b_chunk_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Accept/ignore decisions for this cycle's push and pop
    always_comb begin
        do_pop_s  = pop & (count_r != '0);
        do_push_s = push & ((count_r != DEPTH_C) | do_pop_s);
        overflow  = push & ~do_push_s;
    end

    // Payload storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/r2b_w_feed_scheduler.sv
// Runs one weight-matrix conversion: reads ROW rows from the weight BRAM into
// the r2b converter, captures every chunk it emits into a FIFO, and streams
// the FIFO out to the MAC-core weight loaders.
// Ports: start/busy/done/err control and status; row_rd_en/row_addr/row_rd_data
// BRAM read side (data one cycle after enable); conv_en/conv_in converter feed;
// conv_out/conv_output_ready/conv_buffer_done converter results;
// out_valid/out_data/out_last/out_ready chunk stream (pop on valid & ready).
module r2b_w_feed_scheduler
    import r2b_sched_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ROW        = 8,
    parameter int COL        = 6,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = calc_data_width(WIDTH, COL),
    parameter int OUT_WIDTH  = calc_out_width(WIDTH, CHUNK_SIZE, NUM_CORES),
    parameter int ADDR_WIDTH = $clog2(ROW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic                  row_rd_en,
    output logic [ADDR_WIDTH-1:0] row_addr,
    input  logic [DATA_WIDTH-1:0] row_rd_data,
    output logic                  conv_en,
    output logic [DATA_WIDTH-1:0] conv_in,
    input  logic [OUT_WIDTH-1:0]  conv_out,
    input  logic                  conv_output_ready,
    input  logic                  conv_buffer_done,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int NUM_OUT = calc_num_out(ROW, COL, CHUNK_SIZE, NUM_CORES);
    localparam int CNT_W   = $clog2(NUM_OUT + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]      NUM_OUT_C   = CNT_W'(NUM_OUT);
    localparam logic [CNT_W-1:0]      LAST_C      = CNT_W'(NUM_OUT - 1);
    localparam logic [FCNT_W-1:0]     START_LIMIT = FCNT_W'(FIFO_DEPTH - NUM_OUT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(ROW - 1);
    // A geometry that cannot tile cleanly keeps the block idle rather than
    // emitting mis-framed chunks.
    localparam logic CFG_OK = (FIFO_DEPTH >= NUM_OUT) && (BLOCK_SIZE > 0) &&
                              (ROW % BLOCK_SIZE == 0) && (COL % BLOCK_SIZE == 0) &&
                              ((ROW * COL) % (CHUNK_SIZE * NUM_CORES) == 0);

    sched_state_e          state_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  row_rd_en_r;
    logic [ADDR_WIDTH-1:0] row_addr_r;
    logic                  conv_en_r;
    logic [1:0]            err_r;
    logic [CNT_W-1:0]      chunk_cnt_r;

    logic                  counting_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  push_last_s;
    logic                  stray_s;
    logic                  drain_exit_s;
    logic                  drain_short_s;
    logic                  start_ok_s;

    logic [OUT_WIDTH:0]    fifo_rdata_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FCNT_W-1:0]     fifo_count_s;
    logic                  fifo_overflow_s;
    logic                  fifo_pop_s;

    // Chunk accounting, DRAIN exit decision and start qualification
    always_comb begin
        counting_s    = 1'b0;
        cnt_next_s    = chunk_cnt_r;
        push_last_s   = 1'b0;
        drain_exit_s  = 1'b0;
        if (((state_r == ST_FEED) || (state_r == ST_DRAIN)) && (chunk_cnt_r != NUM_OUT_C)) begin
            counting_s = conv_output_ready;
        end else begin
            counting_s = 1'b0;
        end
        if (counting_s) begin
            cnt_next_s  = chunk_cnt_r + CNT_W'(1'b1);
            push_last_s = (chunk_cnt_r == LAST_C);
        end else begin
            cnt_next_s  = chunk_cnt_r;
            push_last_s = 1'b0;
        end
        // Chunks outside a matrix window (or beyond NUM_OUT) are still stored but flagged
        stray_s = conv_output_ready & ~counting_s;
        // Counting the chunk arriving this cycle lets the exit coincide with the last chunk
        if (state_r == ST_DRAIN) begin
            drain_exit_s = conv_buffer_done | (cnt_next_s == NUM_OUT_C);
        end else begin
            drain_exit_s = 1'b0;
        end
        drain_short_s = drain_exit_s & (cnt_next_s != NUM_OUT_C);
        // Only start when a whole matrix is guaranteed to fit
        start_ok_s    = CFG_OK & start & ~fifo_full_s & (fifo_count_s <= START_LIMIT);
        fifo_pop_s    = out_ready & ~fifo_empty_s;
    end

    // Main sequencer: row reads, converter enable, done/busy and chunk counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            row_rd_en_r <= 1'b0;
            row_addr_r  <= '0;
            conv_en_r   <= 1'b0;
            chunk_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r    <= 1'b0;
                    conv_en_r <= 1'b0;
                    if (start_ok_s) begin
                        state_r     <= ST_FEED;
                        busy_r      <= 1'b1;
                        row_rd_en_r <= 1'b1;
                        row_addr_r  <= '0;
                    end
                end
                ST_FEED: begin
                    // BRAM data lags the read by one cycle, so the enable follows it
                    conv_en_r   <= row_rd_en_r;
                    chunk_cnt_r <= cnt_next_s;
                    if (row_addr_r == LAST_ADDR) begin
                        row_rd_en_r <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        row_addr_r  <= row_addr_r + ADDR_WIDTH'(1'b1);
                    end
                end
                ST_DRAIN: begin
                    chunk_cnt_r <= cnt_next_s;
                    if (drain_exit_s) begin
                        state_r   <= ST_DONE;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        conv_en_r <= 1'b0;
                    end else begin
                        conv_en_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b0;
                    chunk_cnt_r <= '0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    row_rd_en_r <= 1'b0;
                    conv_en_r   <= 1'b0;
                    chunk_cnt_r <= '0;
                end
            endcase
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 2'b00;
        end else begin
            if (fifo_overflow_s) begin
                err_r[ERR_OVF] <= 1'b1;
            end
            if (stray_s || drain_short_s) begin
                err_r[ERR_CNT] <= 1'b1;
            end
        end
    end

    r2b_chunk_fifo #(
        .W     (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (conv_output_ready),
        .wdata    ({push_last_s, conv_out}),
        .pop      (fifo_pop_s),
        .rdata    (fifo_rdata_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s),
        .overflow (fifo_overflow_s)
    );

    // Head of the FIFO, forced to zero when nothing is stored
    always_comb begin
        if (fifo_empty_s) begin
            out_data = '0;
            out_last = 1'b0;
        end else begin
            out_data = fifo_rdata_s[OUT_WIDTH-1:0];
            out_last = fifo_rdata_s[OUT_WIDTH];
        end
    end

    assign out_valid = ~fifo_empty_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign row_rd_en = row_rd_en_r;
    assign row_addr  = row_addr_r;
    assign conv_en   = conv_en_r;
    assign conv_in   = row_rd_data;

endmodule

// File: tb/tb_r2b_w_feed_scheduler.sv
`timescale 1ns/1ps
module tb_r2b_w_feed_scheduler;

    localparam int WIDTH = 16;
    localparam int ROW   = 8;
    localparam int COL   = 6;
    localparam int CHUNK = 4;
    localparam int NOUT  = 12;
    localparam int DW    = WIDTH * COL;
    localparam int OW    = WIDTH * CHUNK;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, row_rd_en, conv_en, out_valid, out_last;
    logic [1:0]    err;
    logic [AW-1:0] row_addr;
    logic [DW-1:0] row_rd_data = '0;
    logic [DW-1:0] conv_in;
    logic [OW-1:0] conv_out = '0;
    logic          conv_output_ready = 1'b0;
    logic          conv_buffer_done = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_ready = 1'b1;

    always #5 clk = ~clk;

    r2b_w_feed_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .row_rd_en(row_rd_en), .row_addr(row_addr), .row_rd_data(row_rd_data),
        .conv_en(conv_en), .conv_in(conv_in), .conv_out(conv_out),
        .conv_output_ready(conv_output_ready), .conv_buffer_done(conv_buffer_done),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    // Weight BRAM: one-cycle read latency
    logic [DW-1:0] bram [ROW];
    always @(posedge clk) begin
        if (row_rd_en) row_rd_data <= bram[row_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [OW:0] sb [$];

    // Converter model state
    bit          m_active = 1'b0;
    int          m_rows, m_idx, m_n;
    bit          m_bd;
    logic [15:0] cap [ROW*COL];
    int          stray_n = 0;
    bit          stray_sb = 1'b0;
    int          stray_k = 0;
    bit          rdy_mode = 1'b1;
    int          done_seen = 0, pops = 0, lasts = 0, sbmax = 0;

    typedef struct {
        logic       start;
        logic       exp_rd;
        logic [2:0] exp_addr;
        logic       chk_addr;
        logic       exp_conv;
        logic       exp_busy;
    } vec_t;
    vec_t vec [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] golden(input int j);
        logic [OW-1:0] v;
        v = '0;
        for (int e = 0; e < CHUNK; e++) v[e*WIDTH +: WIDTH] = 16'((j*CHUNK + e) * 256);
        return v;
    endfunction

    // One clock: observe at the falling edge, then drive inputs for the next rising edge
    task automatic cycle();
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        if (conv_en && m_active && m_rows < ROW) begin
            for (int c = 0; c < COL; c++) cap[m_rows*COL + c] = conv_in[c*WIDTH +: WIDTH];
            m_rows++;
        end
        conv_output_ready = 1'b0;
        conv_buffer_done  = 1'b0;
        conv_out          = '0;
        if (m_active && m_rows == ROW) begin
            if (m_idx < m_n) begin
                conv_output_ready = 1'b1;
                for (int e = 0; e < CHUNK; e++) conv_out[e*WIDTH +: WIDTH] = cap[m_idx*CHUNK + e];
                sb.push_back({(m_idx == NOUT-1) ? 1'b1 : 1'b0, golden(m_idx)});
                m_idx++;
            end else if (!m_bd) begin
                conv_buffer_done = 1'b1;
                m_bd = 1'b1;
            end
        end
        if (stray_n > 0) begin
            conv_output_ready = 1'b1;
            conv_out = 64'hA5A5_0000_0000_0000 | 64'(stray_k);
            if (stray_sb) sb.push_back({1'b0, conv_out});
            stray_k++;
            stray_n--;
        end
        out_ready = rdy_mode;
        if (out_valid && out_ready) begin
            pops++;
            if (out_last) lasts++;
            if (sb.size() == 0) begin
                chk("unexpected_pop", {out_last, out_data}, '0);
            end else begin
                chk("out_chunk", {out_last, out_data}, sb.pop_front());
            end
        end
        if (sb.size() > sbmax) sbmax = sb.size();
    endtask

    task automatic clear_stats();
        pops = 0; lasts = 0; sbmax = 0;
    endtask

    task automatic model_start(input int n);
        m_active = 1'b1; m_rows = 0; m_idx = 0; m_n = n; m_bd = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 100 && done_seen == d0; i++) cycle();
        cycle(); cycle();
        chk("done_pulses", 128'(done_seen - d0), 128'd1);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic run_matrix(input int n);
        int d0;
        d0 = done_seen;
        model_start(n);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("busy_on_accept", busy, 1'b1);
        wait_done(d0);
    endtask

    task automatic drain_all();
        rdy_mode = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) cycle();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < ROW; i++)
            for (int c = 0; c < COL; c++) bram[i][c*WIDTH +: WIDTH] = 16'((i*COL + c) * 256);
        for (int c = 0; c < 11; c++) begin
            vec[c].start    = (c == 0);
            vec[c].exp_rd   = (c >= 1 && c <= 8);
            vec[c].exp_addr = (c >= 1 && c <= 8) ? 3'(c - 1) : 3'd0;
            vec[c].chk_addr = (c <= 8);
            vec[c].exp_conv = (c >= 2);
            vec[c].exp_busy = (c >= 1);
        end

        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        chk("reset_state", {busy, done, row_rd_en, conv_en, out_valid, out_last, row_addr, err}, '0);

        // Nominal matrix with cycle-accurate feed timing
        clear_stats();
        model_start(NOUT);
        for (int c = 0; c < 11; c++) begin
            cycle();
            chk($sformatf("rd_en_c%0d", c), row_rd_en, vec[c].exp_rd);
            if (vec[c].chk_addr) chk($sformatf("addr_c%0d", c), row_addr, vec[c].exp_addr);
            chk($sformatf("conv_en_c%0d", c), conv_en, vec[c].exp_conv);
            chk($sformatf("busy_c%0d", c), busy, vec[c].exp_busy);
            start = vec[c].start;
        end
        wait_done(0);
        cycle(); cycle();
        chk("t1_pops", 128'(pops), 128'(NOUT));
        chk("t1_last_count", 128'(lasts), 128'd1);
        chk("t1_err", err, 2'b00);

        // Backpressure: whole matrix held, second start refused
        clear_stats();
        rdy_mode = 1'b0;
        run_matrix(NOUT);
        chk("t2_valid_held", out_valid, 1'b1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle(); cycle();
        chk("t2_start_refused_busy", busy, 1'b0);
        chk("t2_start_refused_rd", row_rd_en, 1'b0);
        chk("t2_nothing_popped", 128'(pops), 128'd0);
        drain_all();
        chk("t2_pops", 128'(pops), 128'(NOUT));
        chk("t2_last_count", 128'(lasts), 128'd1);

        // Concurrent push/pop: occupancy stays at one
        clear_stats();
        run_matrix(NOUT);
        cycle(); cycle();
        chk("t3_occupancy_max", 128'(sbmax), 128'd1);
        chk("t3_pops", 128'(pops), 128'(NOUT));
        chk("t3_err", err, 2'b00);

        // Short matrix ended by buffer_done after 10 chunks
        clear_stats();
        run_matrix(10);
        cycle(); cycle();
        chk("t4_err", err, 2'b10);
        chk("t4_no_last", 128'(lasts), 128'd0);
        chk("t4_pops", 128'(pops), 128'd10);

        // Reset in the middle of FEED
        clear_stats();
        model_start(NOUT);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        rst_n = 1'b0;
        #1;
        chk("t5_outputs_cleared", {busy, done, row_rd_en, conv_en, out_valid, out_last, row_addr, err}, '0);
        m_active = 1'b0;
        sb.delete();
        cycle(); cycle();
        rst_n = 1'b1;
        begin
            int d0;
            d0 = done_seen;
            for (int i = 0; i < 6; i++) cycle();
            chk("t5_no_done", 128'(done_seen - d0), 128'd0);
        end
        chk("t5_fifo_empty", out_valid, 1'b0);
        clear_stats();
        run_matrix(NOUT);
        cycle(); cycle();
        chk("t5_pops", 128'(pops), 128'(NOUT));
        chk("t5_last_count", 128'(lasts), 128'd1);
        chk("t5_err", err, 2'b00);

        // Overflow: fill to 16 then push 4 more outside any matrix
        clear_stats();
        rdy_mode = 1'b0;
        run_matrix(NOUT);
        stray_sb = 1'b1; stray_n = 4;
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_no_overflow_yet", err[0], 1'b0);
        stray_sb = 1'b0; stray_n = 4;
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_err", err, 2'b11);
        drain_all();
        chk("t6_pops", 128'(pops), 128'd16);
        chk("t6_scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
